// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scanline darkening stage.
package vga_pkg;

    // Pipeline depth of the scanline stage, in ce_pix-qualified cycles.
    localparam int unsigned VGA_PIPE = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [1:0] {
        SL_OFF = 2'd0,
        SL_25  = 2'd1,
        SL_50  = 2'd2,
        SL_75  = 2'd3
    } scan_mode_e;

endpackage

// File: rtl/scanline_chan.sv
// One 8-bit colour channel of the scanline stage: optional darkening, registered output.
module scanline_chan
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] value,
    input  logic       dark,
    input  scan_mode_e mode,
    output logic [7:0] result
);

    logic [7:0] result_d;
    logic [7:0] result_q;

    // Select the dimmed or untouched channel value.
    always_comb begin
        result_d = value;
        if (dark) begin
            unique case (mode)
                SL_25:   result_d = value - (value >> 2);
                SL_50:   result_d = value >> 1;
                SL_75:   result_d = value >> 2;
                default: result_d = value;
            endcase
        end
    end

    // Output register, advancing only on pixel enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else if (ce) begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/vga_scanlines.sv
// Alternate-line darkening for VGA output, with syncs and DE delayed to match the colour path.
module vga_scanlines
    import vga_pkg::*;
#(
    parameter int unsigned PIPE = VGA_PIPE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [1:0]  mode,
    input  logic        phase_sel,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic [23:0] din,
    output logic [23:0] dout,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out
);

    if (PIPE != VGA_PIPE) begin : g_bad_pipe
        $error("vga_scanlines: only PIPE = 2 is supported");
    end

    logic       hs_prev_d, hs_prev_q;
    logic       vs_prev_d, vs_prev_q;
    logic       parity_d,  parity_q;
    scan_mode_e mode_d,    mode_q;

    rgb888_t    pix_s1_q;
    logic       de_s1_q, hs_s1_q, vs_s1_q, dark_s1_q;
    scan_mode_e mode_s1_q;
    logic       dark_d;

    logic       hs_s2_q, vs_s2_q, de_s2_q;
    rgb888_t    pix_gated;
    rgb888_t    pix_out;

    // Edge detection, line parity and frame-boundary mode latch; dark uses post-edge state.
    always_comb begin
        hs_prev_d = hs_in;
        vs_prev_d = vs_in;
        parity_d  = parity_q;
        mode_d    = mode_q;
        if (vs_in && !vs_prev_q) begin
            parity_d = 1'b0;
            mode_d   = scan_mode_e'(mode);
        end else if (hs_in && !hs_prev_q) begin
            parity_d = ~parity_q;
        end
        dark_d = (parity_d ^ phase_sel) && (mode_d != SL_OFF);
    end

    // Control state, stage-1 capture and the stage-2 sync/DE delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            parity_q  <= 1'b0;
            mode_q    <= SL_OFF;
            pix_s1_q  <= '0;
            de_s1_q   <= 1'b0;
            hs_s1_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
            dark_s1_q <= 1'b0;
            mode_s1_q <= SL_OFF;
            hs_s2_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            de_s2_q   <= 1'b0;
        end else if (ce_pix) begin
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            parity_q  <= parity_d;
            mode_q    <= mode_d;
            pix_s1_q  <= din;
            de_s1_q   <= de_in;
            hs_s1_q   <= hs_in;
            vs_s1_q   <= vs_in;
            dark_s1_q <= dark_d;
            mode_s1_q <= mode_d;
            hs_s2_q   <= hs_s1_q;
            vs_s2_q   <= vs_s1_q;
            de_s2_q   <= de_s1_q;
        end
    end

    // Blanking is applied before the channels so their register holds zero.
    assign pix_gated = de_s1_q ? pix_s1_q : '0;

    scanline_chan u_chan_r (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce_pix),
        .value  (pix_gated.r),
        .dark   (dark_s1_q),
        .mode   (mode_s1_q),
        .result (pix_out.r)
    );

    scanline_chan u_chan_g (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce_pix),
        .value  (pix_gated.g),
        .dark   (dark_s1_q),
        .mode   (mode_s1_q),
        .result (pix_out.g)
    );

    scanline_chan u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce_pix),
        .value  (pix_gated.b),
        .dark   (dark_s1_q),
        .mode   (mode_s1_q),
        .result (pix_out.b)
    );

    assign dout   = pix_out;
    assign hs_out = hs_s2_q;
    assign vs_out = vs_s2_q;
    assign de_out = de_s2_q;

endmodule

// File: tb/tb_vga_scanlines.sv
// Randomised and directed bench for vga_scanlines against a line-counting reference model.
module tb_vga_scanlines;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        phase_sel = 1'b0;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic        de_in = 1'b0;
    logic [23:0] din = '0;
    logic [23:0] dout;
    logic        hs_out, vs_out, de_out;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    vga_scanlines #(.PIPE(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .mode      (mode),
        .phase_sel (phase_sel),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .de_in     (de_in),
        .din       (din),
        .dout      (dout),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .de_out    (de_out)
    );

    always #5 clk = ~clk;

    // Reference model: count lines since the last vs rise, apply percentages.
    typedef struct packed {
        logic [23:0] px;
        logic        hs;
        logic        vs;
        logic        de;
    } smp_t;

    smp_t        stage[$];
    smp_t        m_out;
    int unsigned line_cnt;
    int unsigned m_mode;
    bit          m_prev_hs, m_prev_vs;

    function automatic logic [7:0] dim(input logic [7:0] c, input int unsigned m);
        int unsigned v;
        v = c;
        case (m)
            1: v = v - v / 4;
            2: v = v / 2;
            3: v = v / 4;
            default: v = c;
        endcase
        return v[7:0];
    endfunction

    task automatic model_step();
        smp_t s;
        bit   dark;
        if (reset) begin
            line_cnt  = 0;
            m_mode    = 0;
            m_prev_hs = 0;
            m_prev_vs = 0;
            stage.delete();
            stage.push_back('0);
            m_out = '0;
        end else if (ce_pix) begin
            if (vs_in && !m_prev_vs) begin
                line_cnt = 0;
                m_mode   = mode;
            end else if (hs_in && !m_prev_hs) begin
                line_cnt++;
            end
            m_prev_hs = hs_in;
            m_prev_vs = vs_in;
            dark = (m_mode != 0) && ((line_cnt % 2) != phase_sel);
            s.hs = hs_in;
            s.vs = vs_in;
            s.de = de_in;
            if (!de_in)
                s.px = '0;
            else if (dark)
                s.px = {dim(din[23:16], m_mode), dim(din[15:8], m_mode), dim(din[7:0], m_mode)};
            else
                s.px = din;
            m_out = stage.pop_front();
            stage.push_back(s);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input logic c, input logic r, input logic h, input logic v,
                        input logic e, input logic [23:0] d);
        ce_pix = c;
        reset  = r;
        hs_in  = h;
        vs_in  = v;
        de_in  = e;
        din    = d;
        @(posedge clk);
        model_step();
        #1;
        check("dout",   {8'd0, dout},    {8'd0, m_out.px});
        check("hs_out", {31'd0, hs_out}, {31'd0, m_out.hs});
        check("vs_out", {31'd0, vs_out}, {31'd0, m_out.vs});
        check("de_out", {31'd0, de_out}, {31'd0, m_out.de});
    endtask

    task automatic vs_pulse();
        tick(1, 0, 0, 1, 0, '0);
        tick(1, 0, 0, 1, 0, '0);
        tick(1, 0, 0, 0, 0, '0);
    endtask

    task automatic hs_pulse();
        tick(1, 0, 1, 0, 0, '0);
        tick(1, 0, 1, 0, 0, '0);
        tick(1, 0, 0, 0, 0, '0);
    endtask

    task automatic pixels(input int unsigned n, input logic [23:0] d);
        for (int unsigned i = 0; i < n; i++) tick(1, 0, 0, 0, 1, d);
    endtask

    initial begin
        int unsigned x, y;
        logic c, h, v, e;

        // Reset and pass-through with mode 0.
        tick(1, 1, 0, 0, 0, '0);
        check("reset_dout", {8'd0, dout}, 32'd0);
        check("reset_de",   {31'd0, de_out}, 32'd0);
        mode = 2'd0;
        pixels(5, 24'h80C0FF);
        check("pass_through", {8'd0, dout}, 32'h0080C0FF);

        // 50% dim on odd lines, restart at next vs.
        mode = 2'd2;
        phase_sel = 1'b0;
        vs_pulse();
        pixels(5, 24'hFF8040);
        check("m2_line0", {8'd0, dout}, 32'h00FF8040);
        hs_pulse();
        pixels(5, 24'hFF8040);
        check("m2_line1", {8'd0, dout}, 32'h007F4020);
        vs_pulse();
        pixels(5, 24'hFF8040);
        check("m2_restart", {8'd0, dout}, 32'h00FF8040);

        // 25% and 75% dim on a dark line.
        mode = 2'd1;
        vs_pulse();
        hs_pulse();
        pixels(5, 24'hFF0403);
        check("m1_dark", {8'd0, dout}, 32'h00C00303);
        mode = 2'd3;
        vs_pulse();
        hs_pulse();
        pixels(5, 24'hFF0403);
        check("m3_dark", {8'd0, dout}, 32'h003F0100);

        // Mode change mid-frame waits for the next vs rise.
        mode = 2'd0;
        vs_pulse();
        hs_pulse();
        pixels(4, 24'hFF8040);
        mode = 2'd3;
        pixels(3, 24'hFF8040);
        check("midframe_hold", {8'd0, dout}, 32'h00FF8040);
        hs_pulse();
        hs_pulse();
        pixels(4, 24'hFF8040);
        check("midframe_hold2", {8'd0, dout}, 32'h00FF8040);
        vs_pulse();
        hs_pulse();
        pixels(4, 24'hFF8040);
        check("after_vs_m3", {8'd0, dout}, 32'h003F2010);

        // Coincident hs/vs rise: vs wins, parity 0 is dark with phase_sel 1.
        mode = 2'd2;
        phase_sel = 1'b1;
        tick(1, 0, 0, 0, 0, '0);
        tick(1, 0, 1, 1, 0, '0);
        tick(1, 0, 0, 0, 0, '0);
        pixels(4, 24'hFF8040);
        check("coincident_dark", {8'd0, dout}, 32'h007F4020);
        tick(1, 0, 0, 0, 0, 24'hFFFFFF);
        tick(1, 0, 0, 0, 1, 24'hFF8040);
        check("blank_dout", {8'd0, dout}, 32'd0);

        // ce 1-of-3, reset mid-line.
        phase_sel = 1'b0;
        for (int unsigned i = 0; i < 9; i++) tick((i % 3) == 0, 0, 0, 0, 1, 24'h123456);
        tick(0, 1, 0, 0, 1, 24'h123456);
        check("rst_mid_dout", {8'd0, dout}, 32'd0);
        check("rst_mid_hs", {29'd0, hs_out, vs_out, de_out}, 32'd0);
        for (int unsigned i = 0; i < 9; i++) tick((i % 3) == 0, 0, 0, 0, 1, 24'hABCDEF);
        check("after_rst_pass", {8'd0, dout}, 32'h00ABCDEF);

        // Randomised raster with sparse ce, random mode/phase, occasional reset.
        x = 0;
        y = 0;
        for (int unsigned t = 0; t < 4000; t++) begin
            if ((t % 150) == 0) begin
                mode      = 2'($urandom_range(0, 3));
                phase_sel = 1'($urandom_range(0, 1));
            end
            c = ($urandom_range(0, 3) != 0);
            h = (x < 2);
            v = (y == 0);
            e = (x >= 4) && (y >= 1) && ($urandom_range(0, 9) != 0);
            tick(c, ($urandom_range(0, 299) == 0), h, v, e, 24'($urandom));
            x = (x == 15) ? 0 : x + 1;
            if (x == 0) y = (y == 9) ? 0 : y + 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vga_scanlines.md
Name: vga_scanlines

Overview:
- Per-line darkening stage for analog VGA output, upstream of the 6-bit-per-channel PWM/dither stage.
- Takes 24-bit RGB plus syncs and DE at pixel rate, and darkens alternate lines by a selectable amount.
- Delays the syncs and DE so they stay aligned with the colour data.
- Its 24-bit output and hsync feed the PWM stage directly.

Parameters:
- PIPE, 2, pipeline depth in ce_pix-qualified cycles; only 2 is supported, and the parameter exists so it can be checked at elaboration.

Ports:
- clk  input  1  pixel-domain clock
- reset  input  1  synchronous, active-high reset
- ce_pix  input  1  pixel clock enable; all state advances only when high
- mode  input  2  0 = off, 1 = 25% dim, 2 = 50% dim, 3 = 75% dim
- phase_sel  input  1  0 = odd lines dark, 1 = even lines dark
- hs_in  input  1  hsync, active high
- vs_in  input  1  vsync, active high
- de_in  input  1  data enable
- din  input  24  RGB888: R[23:16], G[15:8], B[7:0]
- dout  output  24  processed RGB888
- hs_out  output  1  hs_in delayed by PIPE
- vs_out  output  1  vs_in delayed by PIPE
- de_out  output  1  de_in delayed by PIPE

Behaviour:
- Reset: dout = 0, hs_out = vs_out = de_out = 0, line parity = 0, latched mode = 0, edge-detect history = 0. Reset overrides ce_pix.
- ce_pix low: every register holds its value, including the edge-detect history.
- Edge detection: rising edges of hs_in and vs_in are found against the previous ce-qualified sample.
- Rising vs_in edge:
  - parity clears to 0.
  - mode is latched into mode_q.
  - mode changes therefore take effect only at a frame boundary, never mid-frame.
- Rising hs_in edge without a vs_in edge: parity toggles.
- hs_in and vs_in rising on the same sample: vs wins, and parity = 0.
- A line is dark when (parity ^ phase_sel) = 1 and mode_q != 0.
- Stage 1 (registered): din, de_in, hs_in and vs_in, plus the dark flag and mode_q.
- Stage 2 (registered), per 8-bit channel c when dark:
  - mode 1: c - (c >> 2)
  - mode 2: c >> 1
  - mode 3: c >> 2
  - all arithmetic is unsigned 8-bit; no overflow is possible.
- Stage 2 when not dark: channel passes unchanged.
- Blanking: when the stage-1 DE is 0, dout = 0 regardless of din.
- Latency: exactly 2 ce_pix cycles for dout, hs_out, vs_out and de_out. All four stay aligned at all times.
- Dark flag timing: derived from parity as it stands after the current sample's edge handling, so the line that begins with an hs rise uses the updated parity.
- Reset asserted mid-line: pipeline and parity flush; the first line after reset is parity 0.

Decomposition:
- Package vga_pkg holds:
  - typedef rgb888_t (packed struct r, g, b of 8 bits each)
  - enum scan_mode_e {SL_OFF, SL_25, SL_50, SL_75}
  - localparam VGA_PIPE = 2
- Sub-module scanline_chan: one 8-bit channel with a registered output. Inputs: clk, reset, ce, value, dark, mode. Instantiated 3 times.
- Top level owns edge detection, parity, mode latch and the sync/DE delay line.

Test Plan:
- Reset, then mode = 0, de = 1, din = 0x80C0FF for 5 cycles → dout = 0x80C0FF from the 2nd ce cycle after the first sample; hs_out/vs_out/de_out are the inputs delayed by 2.
- mode = 2, phase_sel = 0, vs pulse, then 2 lines of din = 0xFF8040:
  - line 0 dout = 0xFF8040
  - line 1 dout = 0x7F4020
  - next vs restarts at line 0 undimmed
- mode = 1 and mode = 3 on a dark line with din = 0xFF0403:
  - mode 1 → 0xC00303
  - mode 3 → 0x3F0100
- mode switched 0→3 mid-frame → no change until the next vs rise, after which dark lines show 75% dim.
- hs and vs rising on the same ce cycle, phase_sel = 1 → parity 0, so that line is dark (even lines dark); de low mid-line → dout = 0 two cycles later.
- ce_pix toggled 1-of-3 with reset asserted mid-line → outputs freeze while ce = 0; reset zeroes all outputs next clk; parity restarts at 0.
